ref_edge_sampler: RTL and testbench

Parametrised reference-edge synchroniser and DLF sampler for the DPLL fast-lock path. It brings the asynchronous `ref_clk` into the `nsh_clk` domain through a configurable synchroniser and detects its rising edge. The edge pulse is delayed through a programmable tap line; the selected taps drive single-cycle sample-enable and decimation strobes. The block latches the DLF word and band code into the oscillator, matrix and band control registers using enables only, with no derived clocks. It sits between the digital loop filter and the DCO control decoders.

---
 rtl/ref_edge_sampler.sv | 146 ++++++++++++++
 tb/tb_ref_edge_sampler.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ref_edge_sampler.sv
`default_nettype none
// ============================================================================
// Module   : ref_edge_sampler
// Purpose  : Brings ref_clk into the nsh_clk domain and detects its rising
//            edge. The edge pulse runs down a tap line. The selected taps
//            drive a sample strobe that latches the DLF word and band code,
//            and a decimation strobe. All loads use enables on nsh_clk.
// Options  : REF_WATCHDOG_EN - compiles in the missing-reference watchdog
//            that drives ref_lost. Without it, ref_lost is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module ref_edge_sampler #(
  parameter int DW          = 16,
  parameter int OSW         = 8,
  parameter int BW          = 8,
  parameter int SYNC_STAGES = 2,
  parameter int LAG_DEPTH   = 4,
  parameter int TIMEOUT     = 1024,
  localparam int LW         = $clog2(LAG_DEPTH)
) (
  input  logic              nsh_clk,
  input  logic              rst,
  input  logic              ref_clk,
  input  logic [DW-1:0]     dlf_out,
  input  logic [BW-1:0]     band,
  input  logic [LW-1:0]     smpl_lag,
  input  logic [LW-1:0]     dec_lag,
  output logic [OSW-1:0]    s_os,
  output logic [DW-OSW-1:0] s_mtrx,
  output logic [BW-1:0]     s_band,
  output logic              smpl_stb,
  output logic              dec_clk,
  output logic              ref_lost
);

  logic [SYNC_STAGES-1:0] r_sync;
  // r_fill tracks which sync stages hold real ref_clk samples rather than
  // reset values. Arming waits for a genuine low sample. Otherwise, a ref_clk
  // that is high at reset release would look like a rising edge.
  logic [SYNC_STAGES-1:0] r_fill;
  logic                   r_det;
  logic                   r_armed;
  logic [LAG_DEPTH-1:0]   r_tap;        // bit i holds tap[i+1]
  logic [LW-1:0]          r_smpl_lag;
  logic [LW-1:0]          r_dec_lag;

  logic w_sync_last;
  logic w_pulse;
  logic w_taps_idle;
  logic w_smpl_hit;

  assign w_sync_last = r_sync[SYNC_STAGES-1];
  assign w_pulse     = w_sync_last & ~r_det & r_armed;
  assign w_taps_idle = (r_tap == '0);
  assign w_smpl_hit  = r_tap[r_smpl_lag];

  // Synchroniser chain, its fill marker and the edge-history flop
  always_ff @(posedge nsh_clk) begin
    if (rst) begin
      r_sync <= '0;
      r_fill <= '0;
      r_det  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], ref_clk};
      r_fill <= {r_fill[SYNC_STAGES-2:0], 1'b1};
      r_det  <= w_sync_last;
    end
  end

  // Arm once a real low level of ref_clk has reached the last sync stage
  always_ff @(posedge nsh_clk) begin
    if (rst) begin
      r_armed <= 1'b0;
    end else if (r_fill[SYNC_STAGES-1] && !w_sync_last) begin
      r_armed <= 1'b1;
    end
  end

  // Tap line; overlapping pulses shift through independently
  always_ff @(posedge nsh_clk) begin
    if (rst) begin
      r_tap <= '0;
    end else begin
      r_tap <= {r_tap[LAG_DEPTH-2:0], w_pulse};
    end
  end

  // Lag selects update only while the tap line is empty, so an in-flight edge never loses or duplicates a strobe
  always_ff @(posedge nsh_clk) begin
    if (rst) begin
      r_smpl_lag <= '0;
      r_dec_lag  <= '0;
    end else if (w_taps_idle) begin
      r_smpl_lag <= smpl_lag;
      r_dec_lag  <= dec_lag;
    end
  end

  // Sample registers load, and strobes fire, on the selected taps
  always_ff @(posedge nsh_clk) begin
    if (rst) begin
      s_os     <= '0;
      s_mtrx   <= '0;
      s_band   <= '0;
      smpl_stb <= 1'b0;
      dec_clk  <= 1'b0;
    end else begin
      smpl_stb <= w_smpl_hit;
      dec_clk  <= r_tap[r_dec_lag];
      if (w_smpl_hit) begin
        s_os   <= dlf_out[OSW-1:0];
        s_mtrx <= dlf_out[DW-1:OSW];
        s_band <= band;
      end
    end
  end

`ifdef REF_WATCHDOG_EN
  localparam int            c_wd_w   = $clog2(TIMEOUT + 1);
  localparam logic [c_wd_w-1:0] c_wd_max = c_wd_w'(TIMEOUT);
  localparam logic [c_wd_w-1:0] c_wd_pre = c_wd_w'(TIMEOUT - 1);
  localparam logic [c_wd_w-1:0] c_wd_one = c_wd_w'(1);

  logic [c_wd_w-1:0] r_wd;

  // Count cycles since the last edge pulse; saturate and flag loss at TIMEOUT
  always_ff @(posedge nsh_clk) begin
    if (rst) begin
      r_wd     <= '0;
      ref_lost <= 1'b0;
    end else if (w_pulse) begin
      r_wd     <= '0;
      ref_lost <= 1'b0;
    end else if (r_wd != c_wd_max) begin
      r_wd <= r_wd + c_wd_one;
      if (r_wd == c_wd_pre) begin
        ref_lost <= 1'b1;
      end
    end
  end
`else
  assign ref_lost = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ref_edge_sampler.sv
`default_nettype none
// ============================================================================
// Module   : tb_ref_edge_sampler
// Purpose  : Directed and random checks of ref_edge_sampler against an
//            event-level reference model. The model records when each
//            ref_clk rise is seen, works out the lag that applies to it,
//            and schedules the strobe cycles that result.
// Options  : REF_WATCHDOG_EN - also checks ref_lost timing (TIMEOUT = 16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ref_edge_sampler;
  localparam int DW = 16, OSW = 8, BW = 8, S = 2, LD = 4, LW = 2, T = 16;
  localparam int MAXN = 4096;

  logic              nsh_clk = 1'b0;
  logic              rst = 1'b1;
  logic              ref_clk = 1'b0;
  logic [DW-1:0]     dlf_out = '0;
  logic [BW-1:0]     band = '0;
  logic [LW-1:0]     smpl_lag = '0;
  logic [LW-1:0]     dec_lag = '0;
  logic [OSW-1:0]    s_os;
  logic [DW-OSW-1:0] s_mtrx;
  logic [BW-1:0]     s_band;
  logic              smpl_stb, dec_clk, ref_lost;

  ref_edge_sampler #(
    .DW(DW), .OSW(OSW), .BW(BW), .SYNC_STAGES(S), .LAG_DEPTH(LD), .TIMEOUT(T)
  ) dut (
    .nsh_clk(nsh_clk), .rst(rst), .ref_clk(ref_clk), .dlf_out(dlf_out),
    .band(band), .smpl_lag(smpl_lag), .dec_lag(dec_lag), .s_os(s_os),
    .s_mtrx(s_mtrx), .s_band(s_band), .smpl_stb(smpl_stb),
    .dec_clk(dec_clk), .ref_lost(ref_lost)
  );

  always #5 nsh_clk = ~nsh_clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state. Edges are counted from reset release, and edge 1
  // is the first edge that samples rst low.
  int          n;
  bit          ref_at [MAXN];
  bit          rise   [MAXN];   // rising edge first captured at this edge (E0)
  bit          sdue   [MAXN];
  bit          ddue   [MAXN];
  int          cap_s, cap_d, wd;
  logic [DW-1:0] exp_dlf;
  logic [BW-1:0] exp_band;
  bit          exp_stb, exp_dec, exp_lost;
  int          stb_cnt, dec_cnt;
  logic [DW-1:0] hold_v;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Advance one nsh_clk edge, update the model from the inputs sampled there, then compare
  task automatic step();
    bit idle, pulse_prev;
    @(posedge nsh_clk);
    if (rst) begin
      n = 0;
      for (int i = 0; i < MAXN; i++) begin
        ref_at[i] = 0; rise[i] = 0; sdue[i] = 0; ddue[i] = 0;
      end
      cap_s = 0; cap_d = 0; wd = 0;
      exp_dlf = '0; exp_band = '0;
      exp_stb = 0; exp_dec = 0; exp_lost = 0;
    end else begin
      n++;
      ref_at[n] = ref_clk;
      rise[n]   = (n >= 2) && ref_clk && !ref_at[n-1];
      // Lags are taken only if no earlier edge still occupies the tap line
      idle = 1;
      for (int m = n - S - LD; m <= n - 1 - S; m++)
        if (m >= 1 && rise[m]) idle = 0;
      if (idle) begin
        cap_s = int'(smpl_lag);
        cap_d = int'(dec_lag);
      end
      pulse_prev = (n - S >= 1) && rise[n-S];
      if (pulse_prev) begin
        sdue[n + 1 + cap_s] = 1;
        ddue[n + 1 + cap_d] = 1;
      end
      exp_stb = sdue[n];
      exp_dec = ddue[n];
      if (exp_stb) begin
        exp_dlf  = dlf_out;
        exp_band = band;
      end
`ifdef REF_WATCHDOG_EN
      if (pulse_prev) begin
        wd = 0; exp_lost = 0;
      end else if (wd < T) begin
        wd++;
        if (wd == T) exp_lost = 1;
      end
`endif
    end
    #1;
    if (smpl_stb === 1'b1) stb_cnt++;
    if (dec_clk === 1'b1) dec_cnt++;
    chk("smpl_stb", 32'(smpl_stb), 32'(exp_stb));
    chk("dec_clk", 32'(dec_clk), 32'(exp_dec));
    chk("s_os", 32'(s_os), 32'(exp_dlf[OSW-1:0]));
    chk("s_mtrx", 32'(s_mtrx), 32'(exp_dlf[DW-1:OSW]));
    chk("s_band", 32'(s_band), 32'(exp_band));
    chk("ref_lost", 32'(ref_lost), 32'(exp_lost));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic steps(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  initial begin
    // ---- ref_clk high across reset release: no edge until it goes low and high again
    ref_clk = 1'b1;
    do_reset();
    chk("reset_s_os", 32'(s_os), 32'h0);
    chk("reset_stb", 32'(smpl_stb), 32'h0);
    stb_cnt = 0; dec_cnt = 0;
    steps(20);
    chk("high_at_release_stb_cnt", 32'(stb_cnt), 32'd0);
    chk("high_at_release_dec_cnt", 32'(dec_cnt), 32'd0);
    ref_clk = 1'b0;
    steps(4);
    ref_clk = 1'b1;
    stb_cnt = 0; dec_cnt = 0;
    steps(12);
    chk("first_rise_stb_cnt", 32'(stb_cnt), 32'd1);
    chk("first_rise_dec_cnt", 32'(dec_cnt), 32'd1);

    // ---- default latency: sample at E3, decimation at E6 with dec_lag 3
    ref_clk = 1'b0;
    do_reset();
    smpl_lag = 2'd0; dec_lag = 2'd3; dlf_out = 16'hA55A; band = 8'h3C;
    steps(6);
    ref_clk = 1'b1;
    step();                  // E0
    steps(3);                // E3
    chk("e3_stb", 32'(smpl_stb), 32'd1);
    chk("e3_s_os", 32'(s_os), 32'h5A);
    chk("e3_s_mtrx", 32'(s_mtrx), 32'hA5);
    chk("e3_s_band", 32'(s_band), 32'h3C);
    steps(3);                // E6
    chk("e6_dec_clk", 32'(dec_clk), 32'd1);

    // ---- sample lag 2 with dlf_out changing every cycle: value present at E5 is held
    ref_clk = 1'b0;
    do_reset();
    smpl_lag = 2'd2; dec_lag = 2'd0;
    steps(6);
    ref_clk = 1'b1;
    step();                  // E0
    hold_v = '0;
    for (int i = 1; i <= 5; i++) begin
      dlf_out = 16'($urandom);
      band    = 8'($urandom);
      if (i == 5) hold_v = dlf_out;
      step();
    end
    chk("lag2_stb", 32'(smpl_stb), 32'd1);
    chk("lag2_value", 32'({s_mtrx, s_os}), 32'(hold_v));
    for (int i = 0; i < 5; i++) begin
      dlf_out = 16'($urandom);
      step();
    end
    chk("lag2_hold", 32'({s_mtrx, s_os}), 32'(hold_v));

    // ---- lag change while a pulse is in flight is deferred to the next edge
    ref_clk = 1'b0;
    do_reset();
    smpl_lag = 2'd0;
    steps(6);
    ref_clk = 1'b1;
    step(); step(); step();  // E0..E2
    smpl_lag = 2'd3;
    stb_cnt = 0;
    step();                  // E3
    chk("deferred_e3_stb", 32'(smpl_stb), 32'd1);
    steps(8);
    chk("deferred_stb_cnt", 32'(stb_cnt), 32'd1);
    ref_clk = 1'b0;
    steps(4);
    ref_clk = 1'b1;
    step();                  // E0 of next edge
    steps(5);
    chk("lag3_e5_stb", 32'(smpl_stb), 32'd0);
    step();                  // E6
    chk("lag3_e6_stb", 32'(smpl_stb), 32'd1);

    // ---- reset at E2 discards the in-flight edge; ref_clk still high needs re-arming
    ref_clk = 1'b0;
    do_reset();
    smpl_lag = 2'd0; dec_lag = 2'd1; dlf_out = 16'h1234; band = 8'h55;
    steps(6);
    ref_clk = 1'b1;
    step(); step(); step();  // E0..E2
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_reset_stb", 32'(smpl_stb), 32'd0);
    chk("mid_reset_s_os", 32'(s_os), 32'd0);
    stb_cnt = 0; dec_cnt = 0;
    steps(10);
    chk("mid_reset_no_stb", 32'(stb_cnt), 32'd0);
    chk("mid_reset_no_dec", 32'(dec_cnt), 32'd0);

`ifdef REF_WATCHDOG_EN
    // ---- watchdog: flag after TIMEOUT idle cycles, clear the cycle after the next pulse
    ref_clk = 1'b0;
    do_reset();
    steps(T - 1);
    chk("wd_before_timeout", 32'(ref_lost), 32'd0);
    step();
    chk("wd_at_timeout", 32'(ref_lost), 32'd1);
    ref_clk = 1'b1;
    step(); step();          // E0, E1 (pulse high now)
    chk("wd_during_pulse", 32'(ref_lost), 32'd1);
    step();                  // E2
    chk("wd_cleared", 32'(ref_lost), 32'd0);
`endif

    // ---- random ref_clk phases, data and lag changes against the model
    ref_clk = 1'b0;
    do_reset();
    begin
      int phase;
      phase = 4;
      for (int c = 0; c < 1500; c++) begin
        dlf_out = 16'($urandom);
        band    = 8'($urandom);
        if ($urandom_range(3) == 0) smpl_lag = 2'($urandom);
        if ($urandom_range(3) == 0) dec_lag  = 2'($urandom);
        if (phase == 0) begin
          ref_clk = ~ref_clk;
          phase = int'($urandom_range(6, 2));
        end
        phase--;
        if (c == 700) rst = 1'b1;
        if (c == 702) rst = 1'b0;
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
